// File: rtl/divider_arbiter_if.sv
// Request/response bundle between two divide clients, their consumer and divider_arbiter.
// master = client/consumer side, slave = arbiter side.
interface divider_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sign;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sign;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_reminder;
  logic             rsp_divzero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sign,
    output req1_valid, req1_a, req1_b, req1_sign,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_quotient, rsp_reminder, rsp_divzero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sign,
    input  req1_valid, req1_a, req1_b, req1_sign,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_quotient, rsp_reminder, rsp_divzero
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one combinational divider between two requesters, operands held LATENCY cycles.
// Optional: DIVIDER_ARBITER_ZERO_FASTPATH_EN makes zero-divisor requests complete one edge after handshake.

module divider #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Magnitude divide, then restore signs: truncation toward zero, remainder follows dividend.
  always_comb begin
    a_neg     = sign & a[WIDTH-1];
    b_neg     = sign & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    q_mag     = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag     = (b_mag == '0) ? '0 : a_mag % b_mag;
    quotient  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    remainder = a_neg ? -r_mag : r_mag;
  end
endmodule

module divider_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  divider_arbiter_if.slave         bus,
  output logic [1:0]               state_o
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // reqN_ready is combinational from state and the valids only; rsp_valid holds until rsp_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_sign_q, op_sign_d;
  logic             last_q, last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_quot_q, rsp_quot_d;
  logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic             grant_valid;
  logic             grant_id;
  logic             hs;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sign;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  divider #(.WIDTH(WIDTH)) u_divider (
    .a         (op_a_q),
    .b         (op_b_q),
    .sign      (op_sign_q),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // With both valid, the requester that was not served last wins.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    hs          = grant_valid && (state_q == IDLE) && !reset;
    sel_a       = grant_id ? bus.req1_a    : bus.req0_a;
    sel_b       = grant_id ? bus.req1_b    : bus.req0_b;
    sel_sign    = grant_id ? bus.req1_sign : bus.req0_sign;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sign_d   = op_sign_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_dz_d    = rsp_dz_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          op_a_d    = sel_a;
          op_b_d    = sel_b;
          op_sign_d = sel_sign;
          rsp_id_d  = grant_id;
`ifdef DIVIDER_ARBITER_ZERO_FASTPATH_EN
          cnt_d     = (sel_b == '0) ? '0 : CNT_LOAD;
`else
          cnt_d     = CNT_LOAD;
`endif
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_quot_d  = (op_b_q == '0) ? '1 : div_q;
          rsp_rem_d   = (op_b_q == '0) ? op_a_q : div_r;
          rsp_dz_d    = (op_b_q == '0);
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so the first contended grant goes to req0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sign_q   <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sign_q   <= op_sign_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_dz_q    <= rsp_dz_d;
    end
  end

  assign bus.req0_ready   = hs & ~grant_id;
  assign bus.req1_ready   = hs & grant_id;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_quotient = rsp_quot_q;
  assign bus.rsp_reminder = rsp_rem_q;
  assign bus.rsp_divzero  = rsp_dz_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter: reset, unsigned/signed division, contention,
// backpressure, divide-by-zero and reset during an in-flight operation.
module tb_divider_arbiter;
  localparam int WIDTH   = 8;
  localparam int LATENCY = 2;
`ifdef DIVIDER_ARBITER_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = LATENCY;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_o;
  int         n_vec = 0;
  int         n_err = 0;

  divider_arbiter_if #(.WIDTH(WIDTH)) bus ();

  divider_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sign = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sign = 1'b0;
    bus.rsp_ready  = 1'b1;
  endtask

  task automatic drive_req(input bit n, input logic [7:0] a, input logic [7:0] b, input bit s);
    if (n) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sign = s;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sign = s;
    end
  endtask

  // Inputs are scrambled after the handshake; the captured operation must not change.
  task automatic drop_req(input bit n);
    if (n) begin
      bus.req1_valid = 1'b0; bus.req1_a = 8'($urandom_range(1, 255)); bus.req1_b = 8'($urandom_range(1, 255));
    end else begin
      bus.req0_valid = 1'b0; bus.req0_a = 8'($urandom_range(1, 255)); bus.req0_b = 8'($urandom_range(1, 255));
    end
  endtask

  task automatic issue(input bit n, input logic [7:0] a, input logic [7:0] b, input bit s,
                       output bit got);
    drive_req(n, a, b, s);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (n ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    drop_req(n);
  endtask

  // Edges after the handshake edge until rsp_valid; 0 means it never came.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
    n_vec++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_req1_ready: got %b want 0", bus.req1_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); end
    n_vec++; if (bus.rsp_quotient !== 8'h00) begin n_err++; $display("FAIL reset_quotient: got %h want 00", bus.rsp_quotient); end
    n_vec++; if (bus.rsp_reminder !== 8'h00) begin n_err++; $display("FAIL reset_reminder: got %h want 00", bus.rsp_reminder); end
    n_vec++; if (bus.rsp_divzero !== 1'b0) begin n_err++; $display("FAIL reset_divzero: got %b want 0", bus.rsp_divzero); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_unsigned();
    logic [7:0] ta [2] = '{8'd42, 8'd214};
    logic [7:0] tb [2] = '{8'd7,  8'd7};
    logic [7:0] tq [2] = '{8'd6,  8'd30};
    logic [7:0] tr [2] = '{8'd0,  8'd4};
    bit got;
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, ta[i], tb[i], 1'b0, got);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL unsigned_grant[%0d]: got %b want 1", i, got); end
      wait_rsp(lat);
      n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, lat, LATENCY); end
      n_vec++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL unsigned_id[%0d]: got %b want 0", i, bus.rsp_id); end
      n_vec++; if (bus.rsp_quotient !== tq[i]) begin n_err++; $display("FAIL unsigned_q[%0d]: got %h want %h", i, bus.rsp_quotient, tq[i]); end
      n_vec++; if (bus.rsp_reminder !== tr[i]) begin n_err++; $display("FAIL unsigned_r[%0d]: got %h want %h", i, bus.rsp_reminder, tr[i]); end
      n_vec++; if (bus.rsp_divzero !== 1'b0) begin n_err++; $display("FAIL unsigned_dz[%0d]: got %b want 0", i, bus.rsp_divzero); end
      @(posedge clk); #1;
      n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL unsigned_valid_drop[%0d]: got %b want 0", i, bus.rsp_valid); end
    end
  endtask

  task automatic test_signed();
    // -42/7, 7/-42, 127/37, -7/2
    logic [7:0] ta [4] = '{8'hD6, 8'h07, 8'h7F, 8'hF9};
    logic [7:0] tb [4] = '{8'h07, 8'hD6, 8'h25, 8'h02};
    logic [7:0] tq [4] = '{8'hFA, 8'h00, 8'h03, 8'hFD};
    logic [7:0] tr [4] = '{8'h00, 8'h07, 8'h10, 8'hFF};
    bit got;
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, ta[i], tb[i], 1'b1, got);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL signed_grant[%0d]: got %b want 1", i, got); end
      wait_rsp(lat);
      n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, LATENCY); end
      n_vec++; if (bus.rsp_id !== 1'b1) begin n_err++; $display("FAIL signed_id[%0d]: got %b want 1", i, bus.rsp_id); end
      n_vec++; if (bus.rsp_quotient !== tq[i]) begin n_err++; $display("FAIL signed_q[%0d]: got %h want %h", i, bus.rsp_quotient, tq[i]); end
      n_vec++; if (bus.rsp_reminder !== tr[i]) begin n_err++; $display("FAIL signed_r[%0d]: got %h want %h", i, bus.rsp_reminder, tr[i]); end
      n_vec++; if (bus.rsp_divzero !== 1'b0) begin n_err++; $display("FAIL signed_dz[%0d]: got %b want 0", i, bus.rsp_divzero); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_divzero();
    logic [7:0] ta [2] = '{8'd42, 8'hD6};
    bit got;
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(i[0], ta[i], 8'h00, i[0], got);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL dz_grant[%0d]: got %b want 1", i, got); end
      wait_rsp(lat);
      n_vec++; if (lat !== ZLAT) begin n_err++; $display("FAIL dz_latency[%0d]: got %0d want %0d", i, lat, ZLAT); end
      n_vec++; if (bus.rsp_id !== i[0]) begin n_err++; $display("FAIL dz_id[%0d]: got %b want %b", i, bus.rsp_id, i[0]); end
      n_vec++; if (bus.rsp_quotient !== 8'hFF) begin n_err++; $display("FAIL dz_q[%0d]: got %h want ff", i, bus.rsp_quotient); end
      n_vec++; if (bus.rsp_reminder !== ta[i]) begin n_err++; $display("FAIL dz_r[%0d]: got %h want %h", i, bus.rsp_reminder, ta[i]); end
      n_vec++; if (bus.rsp_divzero !== 1'b1) begin n_err++; $display("FAIL dz_flag[%0d]: got %b want 1", i, bus.rsp_divzero); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit got;
    int lat;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 8'd50, 8'd5, 1'b0, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL bp_grant: got %b want 1", got); end
    wait_rsp(lat);
    n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, LATENCY); end
    drive_req(1'b0, 8'd9, 8'd0, 1'b1);
    drive_req(1'b1, 8'd8, 8'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus.rsp_valid); end
      n_vec++; if (bus.rsp_quotient !== 8'd10 || bus.rsp_reminder !== 8'd0 || bus.rsp_divzero !== 1'b0 || bus.rsp_id !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got q=%h r=%h dz=%b id=%b want q=0a r=00 dz=0 id=0", k, bus.rsp_quotient, bus.rsp_reminder, bus.rsp_divzero, bus.rsp_id);
      end
      n_vec++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_readies[%0d]: got %b%b want 00", k, bus.req0_ready, bus.req1_ready);
      end
    end
    drop_req(1'b0);
    drop_req(1'b1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", bus.rsp_valid); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL bp_release_state: got %0d want 0", state_o); end
  endtask

  task automatic test_contention();
    bit g_id [8];
    int g_cyc [8];
    int gi = 0;
    int n_rsp = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_req(1'b0, 8'd100, 8'd10, 1'b0);
    drive_req(1'b1, 8'hF6, 8'h03, 1'b1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      n_vec++; if (bus.req0_ready && bus.req1_ready) begin n_err++; $display("FAIL cont_both_ready[%0d]: got 11 want at most one", cyc); end
      if ((bus.req0_ready || bus.req1_ready) && gi < 8) begin
        g_id[gi]  = bus.req1_ready;
        g_cyc[gi] = cyc;
        gi++;
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        if (bus.rsp_id) begin
          n_vec++; if (bus.rsp_quotient !== 8'hFD || bus.rsp_reminder !== 8'hFF) begin
            n_err++; $display("FAIL cont_rsp1[%0d]: got q=%h r=%h want q=fd r=ff", cyc, bus.rsp_quotient, bus.rsp_reminder);
          end
        end else begin
          n_vec++; if (bus.rsp_quotient !== 8'd10 || bus.rsp_reminder !== 8'd0) begin
            n_err++; $display("FAIL cont_rsp0[%0d]: got q=%h r=%h want q=0a r=00", cyc, bus.rsp_quotient, bus.rsp_reminder);
          end
        end
      end
    end
    n_vec++; if (gi < 4) begin n_err++; $display("FAIL cont_grant_count: got %0d want >=4", gi); end
    n_vec++; if (n_rsp < 4) begin n_err++; $display("FAIL cont_rsp_count: got %0d want >=4", n_rsp); end
    for (int i = 0; i < 4 && i < gi; i++) begin
      n_vec++; if (g_id[i] !== i[0]) begin n_err++; $display("FAIL cont_order[%0d]: got %b want %b", i, g_id[i], i[0]); end
      if (i > 0) begin
        n_vec++; if (g_cyc[i] - g_cyc[i-1] !== LATENCY + 2) begin
          n_err++; $display("FAIL cont_period[%0d]: got %0d want %0d", i, g_cyc[i] - g_cyc[i-1], LATENCY + 2);
        end
      end
    end
    @(posedge clk); #1;
    drop_req(1'b0);
    drop_req(1'b1);
    repeat (2 * (LATENCY + 2)) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_wait();
    bit got;
    int lat;
    issue(1'b0, 8'd9, 8'd3, 1'b0, got);
    wait_rsp(lat);
    n_vec++; if (bus.rsp_quotient !== 8'd3) begin n_err++; $display("FAIL rw_pre_q: got %h want 03", bus.rsp_quotient); end
    @(posedge clk); #1;
    issue(1'b1, 8'd100, 8'd7, 1'b0, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL rw_grant1: got %b want 1", got); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL rw_state: got %0d want 0", state_o); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rw_no_rsp[%0d]: got %b want 0", k, bus.rsp_valid); end
    end
    @(posedge clk); #1;
    drive_req(1'b0, 8'd20, 8'd4, 1'b0);
    drive_req(1'b1, 8'd30, 8'd4, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL rw_regrant: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    drop_req(1'b0);
    drop_req(1'b1);
    wait_rsp(lat);
    n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL rw_latency: got %0d want %0d", lat, LATENCY); end
    n_vec++; if (bus.rsp_id !== 1'b0 || bus.rsp_quotient !== 8'd5 || bus.rsp_reminder !== 8'd0) begin
      n_err++; $display("FAIL rw_rsp: got id=%b q=%h r=%h want id=0 q=05 r=00", bus.rsp_id, bus.rsp_quotient, bus.rsp_reminder);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_backpressure();
    test_contention();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
